// File: rtl/psum_drain.sv
// psum_drain: drains 3x6 PE partial-sum words from a FIFO, accumulates them
// over a configurable number of input-channel passes, then quantizes the
// accumulators to bytes and streams the group out as three 6-byte rows.

// Per-element quantizer: arithmetic shift followed by ReLU/u8 or s8 clamp.
module psum_quant #(
  parameter int ACC_WIDTH = 20
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [4:0]           shift,
  input  logic                 relu,
  output logic [7:0]           q
);
  localparam logic signed [ACC_WIDTH-1:0] U8_MAX = ACC_WIDTH'(255);
  localparam logic signed [ACC_WIDTH-1:0] S8_MAX = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] S8_MIN = ACC_WIDTH'(-128);

  logic signed [ACC_WIDTH-1:0] sh;

  assign sh = $signed(acc) >>> shift;

  // Clamp the shifted value into the selected byte range.
  always_comb begin
    q = sh[7:0];
    if (relu) begin
      if (sh < 0)           q = 8'h00;
      else if (sh > U8_MAX) q = 8'hFF;
    end else begin
      if (sh > S8_MAX)      q = 8'h7F;
      else if (sh < S8_MIN) q = 8'h80;
    end
  end
endmodule

module psum_drain #(
  parameter int PSUM_WIDTH = 16,
  parameter int ACC_WIDTH  = PSUM_WIDTH + 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic [3:0]               cfg_num_ch_i,
  input  logic [4:0]               cfg_shift_i,
  input  logic                     cfg_relu_i,
  input  logic                     fifo_empty_i,
  input  logic [18*PSUM_WIDTH-1:0] fifo_dout_i,
  output logic                     fifo_rd_en_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [47:0]              out_data_o,
  output logic [1:0]               out_row_o,
  output logic                     out_last_o,
  output logic                     busy_o
);
  localparam int NE = 18;

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_OUT} state_t;

  state_t     state_q, state_d;
  logic       rd_q, rd_d;
  logic [3:0] ch_cnt, ch_d;
  logic [1:0] row_cnt, row_d;

  logic [3:0] num_ch;
  logic [4:0] shift;
  logic       relu;

  logic [NE-1:0][ACC_WIDTH-1:0] acc;
  logic [NE-1:0][ACC_WIDTH-1:0] psext;
  logic [NE-1:0][7:0]           qb;
  logic [2:0][47:0]             rows;

  logic [3:0] cfg_ch_eff;
  logic [3:0] num_eff;
  logic       last_ch;
  logic       xfer;

  // A zero channel count means a single pass; the first capture of a group
  // uses the live config since num_ch is only being latched in that cycle.
  assign cfg_ch_eff = (cfg_num_ch_i == 4'd0) ? 4'd1 : cfg_num_ch_i;
  assign num_eff    = (ch_cnt == 4'd0) ? cfg_ch_eff : num_ch;
  assign last_ch    = (ch_cnt == num_eff - 4'd1);
  assign xfer       = out_valid_o && out_ready_i;

  // Per-element sign extension, quantization and row packing.
  for (genvar e = 0; e < NE; e++) begin : g_lane
    assign psext[e] = ACC_WIDTH'($signed(fifo_dout_i[e*PSUM_WIDTH +: PSUM_WIDTH]));
    psum_quant #(.ACC_WIDTH(ACC_WIDTH)) u_quant (
      .acc   (acc[e]),
      .shift (shift),
      .relu  (relu),
      .q     (qb[e])
    );
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign rows[r] = qb[r*6 +: 6];
  end

  // State, read strobe and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      ch_cnt  <= 4'd0;
      row_cnt <= 2'd0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      ch_cnt  <= ch_d;
      row_cnt <= row_d;
    end
  end

  // Next state: the read strobe is issued from S_IDLE (or pre-armed on the
  // final row transfer) and the word is captured in the following cycle.
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    ch_d    = ch_cnt;
    row_d   = row_cnt;
    case (state_q)
      S_IDLE: begin
        if (rd_q)               state_d = S_CAPT;
        else if (!fifo_empty_i) rd_d    = 1'b1;
      end
      S_CAPT: begin
        if (last_ch) begin
          ch_d    = 4'd0;
          state_d = S_OUT;
        end else begin
          ch_d    = ch_cnt + 4'd1;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (xfer) begin
          if (row_cnt == 2'd2) begin
            row_d   = 2'd0;
            state_d = S_IDLE;
            rd_d    = !fifo_empty_i;
          end else begin
            row_d   = row_cnt + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear_i) begin
      state_d = S_IDLE;
      rd_d    = 1'b0;
      ch_d    = 4'd0;
      row_d   = 2'd0;
    end
  end

  // Outputs are decoded from registered state only; data is gated off
  // outside S_OUT so an aborted group leaves nothing on the bus.
  always_comb begin
    fifo_rd_en_o = rd_q;
    out_valid_o  = (state_q == S_OUT);
    out_row_o    = 2'd0;
    out_last_o   = 1'b0;
    out_data_o   = 48'd0;
    busy_o       = (state_q != S_IDLE) || (ch_cnt != 4'd0);
    if (state_q == S_OUT) begin
      out_row_o  = row_cnt;
      out_last_o = (row_cnt == 2'd2);
      case (row_cnt)
        2'd1:    out_data_o = rows[1];
        2'd2:    out_data_o = rows[2];
        default: out_data_o = rows[0];
      endcase
    end
  end

  // Accumulators and per-group config; the first pass loads, later passes
  // add with plain wrap-around. A clear drops the word being captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      num_ch <= 4'd1;
      shift  <= 5'd0;
      relu   <= 1'b1;
    end else if (!clear_i && state_q == S_CAPT) begin
      if (ch_cnt == 4'd0) begin
        acc    <= psext;
        num_ch <= cfg_ch_eff;
        shift  <= cfg_shift_i;
        relu   <= cfg_relu_i;
      end else begin
        for (int e = 0; e < NE; e++) acc[e] <= acc[e] + psext[e];
      end
    end
  end
endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with a 1-cycle-latency FIFO model.
module tb_psum_drain;
  localparam int PW = 16;

  logic           clk = 1'b0;
  logic           rst, clear_i;
  logic [3:0]     cfg_num_ch_i;
  logic [4:0]     cfg_shift_i;
  logic           cfg_relu_i;
  logic           fifo_empty_i;
  logic [18*PW-1:0] fifo_dout_i;
  logic           fifo_rd_en_o;
  logic           out_valid_o, out_ready_i;
  logic [47:0]    out_data_o;
  logic [1:0]     out_row_o;
  logic           out_last_o, busy_o;

  psum_drain #(.PSUM_WIDTH(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .cfg_num_ch_i (cfg_num_ch_i),
    .cfg_shift_i  (cfg_shift_i),
    .cfg_relu_i   (cfg_relu_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_dout_i  (fifo_dout_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_row_o    (out_row_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes come from the stimulus process, pops on rd_en with
  // data appearing just after the edge, i.e. valid in the next cycle.
  logic [18*PW-1:0] mem [64];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int strb   = 0;
  logic rd_s;

  assign fifo_empty_i = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    rd_s = fifo_rd_en_o;
    #1;
    if (rd_s === 1'b1) begin
      strb = strb + 1;
      if (rd_cnt != wr_cnt) begin
        fifo_dout_i = mem[rd_cnt % 64];
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  int nchk  = 0;
  int nfail = 0;
  int e [18];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 18; i++) e[i] = v;
  endtask

  task automatic push();
    logic [18*PW-1:0] w;
    for (int i = 0; i < 18; i++) w[i*PW +: PW] = PW'(e[i]);
    mem[wr_cnt % 64] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("vld_wait", out_valid_o, 1);
  endtask

  // Expects valid now and out_ready_i=1; checks three back-to-back rows.
  task automatic rows3(input string tag, input logic [47:0] r0, input logic [47:0] r1,
                       input logic [47:0] r2);
    logic [47:0] ex [3];
    ex[0] = r0; ex[1] = r1; ex[2] = r2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_v%0d", tag, i), out_valid_o, 1);
      chk($sformatf("%s_r%0d", tag, i), out_row_o, i);
      chk($sformatf("%s_l%0d", tag, i), out_last_o, (i == 2));
      chk($sformatf("%s_d%0d", tag, i), out_data_o, ex[i]);
      @(negedge clk);
    end
    chk($sformatf("%s_done", tag), out_valid_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, s0;
    rst = 1'b1; clear_i = 1'b0; out_ready_i = 1'b1;
    cfg_num_ch_i = 4'd1; cfg_shift_i = 5'd0; cfg_relu_i = 1'b1;
    fill(100); push();

    // Reset with a non-empty FIFO.
    @(negedge clk); chk("rst_rd0", fifo_rd_en_o, 0);
    @(negedge clk); chk("rst_rd1", fifo_rd_en_o, 0);
    chk("rst_vld", out_valid_o, 0);
    chk("rst_dat", out_data_o, 0);
    chk("rst_row", out_row_o, 0);
    chk("rst_lst", out_last_o, 0);
    chk("rst_bsy", busy_o, 0);
    rst = 1'b0;
    @(negedge clk); chk("rel_rd", fifo_rd_en_o, 1);

    // Single pass, ReLU, no shift.
    wait_valid(n);
    chk("sp_lat", n, 2);
    rows3("sp", 48'h646464646464, 48'h646464646464, 48'h646464646464);

    // Three channels, shift 2; mid-group config change must be ignored.
    cfg_num_ch_i = 4'd3; cfg_shift_i = 5'd2;
    s0 = strb;
    fill(50); push(); fill(60); push(); fill(-10); push();
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(negedge clk); n++;
      if (strb - s0 == 2) begin cfg_num_ch_i = 4'd1; cfg_shift_i = 5'd0; end
    end
    chk("mc_vld", out_valid_o, 1);
    chk("mc_strb", strb - s0, 3);
    rows3("mc", 48'h191919191919, 48'h191919191919, 48'h191919191919);

    // ReLU clamp boundaries.
    cfg_num_ch_i = 4'd1; cfg_shift_i = 5'd0; cfg_relu_i = 1'b1;
    fill(100); e[0] = 1000; e[1] = -5; e[6] = 255; e[7] = 256; e[8] = 0; e[9] = -1;
    push();
    wait_valid(n);
    rows3("ru", 48'h6464646400FF, 48'h64640000FFFF, 48'h646464646464);

    // Signed clamp boundaries with arithmetic shift of negatives.
    cfg_relu_i = 1'b0; cfg_shift_i = 5'd1;
    fill(200); e[0] = -9; e[1] = 600; e[2] = -600;
    e[6] = -256; e[7] = 254; e[8] = 256; e[9] = -258;
    push();
    wait_valid(n);
    rows3("sg", 48'h646464807FFB, 48'h6464807F7F80, 48'h646464646464);

    // Backpressure on row 1 with the next word already queued.
    cfg_relu_i = 1'b1; cfg_shift_i = 5'd0;
    fill(100); push(); fill(7); push();
    wait_valid(n);
    chk("bp_r0", out_row_o, 0);
    @(negedge clk);
    out_ready_i = 1'b0;
    s0 = strb;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_v", out_valid_o, 1);
      chk("bp_hold_r", out_row_o, 1);
      chk("bp_hold_d", out_data_o, 48'h646464646464);
      @(negedge clk);
    end
    chk("bp_nord", strb - s0, 0);
    out_ready_i = 1'b1;
    chk("bp_r1", out_row_o, 1);
    @(negedge clk);
    chk("bp_r2", out_row_o, 2);
    chk("bp_l2", out_last_o, 1);
    @(negedge clk);
    chk("bp_rd", fifo_rd_en_o, 1);
    chk("bp_v0", out_valid_o, 0);
    wait_valid(n);
    rows3("bp2", 48'h070707070707, 48'h070707070707, 48'h070707070707);

    // Clear after the first capture of a 3-channel group.
    cfg_num_ch_i = 4'd3;
    fill(50); push();
    n = 0;
    while (!fifo_rd_en_o && n < 20) begin @(negedge clk); n++; end
    chk("clr_rd", fifo_rd_en_o, 1);
    @(negedge clk);
    @(negedge clk);
    chk("clr_bsy1", busy_o, 1);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk("clr_bsy0", busy_o, 0);
    chk("clr_vld0", out_valid_o, 0);
    s0 = strb;
    fill(7); push(); push(); push();
    wait_valid(n);
    chk("clr_strb", strb - s0, 3);
    rows3("clr", 48'h151515151515, 48'h151515151515, 48'h151515151515);

    // Reset during output discards the group.
    cfg_num_ch_i = 4'd1; out_ready_i = 1'b0;
    fill(100); push();
    wait_valid(n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_vld", out_valid_o, 0);
    chk("mr_bsy", busy_o, 0);
    chk("mr_dat", out_data_o, 0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_novld", out_valid_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
